// File: rtl/regfile_dump_reader_if.sv
// Bundle of the dump engine's control, register-file read port and output stream.
// The slave modport is the dump engine; the master modport is the surrounding system.
interface regfile_dump_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport slave (
    input  start, rd_data, out_ready,
    output busy, done, rd_addr, out_valid, out_addr, out_data, out_last
  );

  modport master (
    output start, rd_data, out_ready,
    input  busy, done, rd_addr, out_valid, out_addr, out_data, out_last
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks the register file one index at a time and streams (address, data) beats.
// Optional REGFILE_DUMP_CHECKSUM_EN appends an XOR checksum beat after the last register.
module regfile_dump_reader #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_dump_reader_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

`ifdef REGFILE_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_READ, S_SEND, S_CSUM, S_DONE} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_READ, S_SEND, S_DONE} state_e;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [ADDR_W-1:0] rd_addr_c;
  logic              busy_c;
  logic              done_c;
  logic              handshake;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  assign handshake = out_valid_q && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // Beat fields are captured only in READ, so later register writes cannot disturb a pending beat
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    rd_addr_c   = '0;
    busy_c      = (state_q != S_IDLE);
    done_c      = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          idx_d   = '0;
          state_d = S_READ;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end

      S_READ: begin
        rd_addr_c   = idx_q;
        out_data_d  = bus.rd_data;
        out_addr_d  = idx_q;
        out_valid_d = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        out_last_d  = 1'b0;
        csum_d      = csum_q ^ bus.rd_data;
`else
        out_last_d  = (idx_q == LAST_IDX);
`endif
        state_d     = S_SEND;
      end

      S_SEND: begin
        rd_addr_c = idx_q;
        if (handshake) begin
          out_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            out_last_d = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            out_valid_d = 1'b1;
            out_addr_d  = '0;
            out_data_d  = csum_q;
            out_last_d  = 1'b1;
            state_d     = S_CSUM;
`else
            state_d     = S_DONE;
`endif
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_READ;
          end
        end
      end

`ifdef REGFILE_DUMP_CHECKSUM_EN
      S_CSUM: begin
        if (handshake) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = S_DONE;
        end
      end
`endif

      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.rd_addr   = rd_addr_c;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: directed dumps push expected beats, a monitor pops them.
// Define REGFILE_DUMP_CHECKSUM_EN to also cover the checksum beat.
module tb_regfile_dump_reader;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam int CSUM_EXTRA = 1;
`else
  localparam int CSUM_EXTRA = 0;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] regs [NUM_REGS];
  beat_t             expQ [$];
  beat_t             monExp;
  int                total = 0;
  int                bad = 0;
  int                doneCycle;

  regfile_dump_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_dump_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.rd_data = regs[bus.rd_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    check({tag, " busy"}, 32'(bus.busy), 32'd0);
    check({tag, " done"}, 32'(bus.done), 32'd0);
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, " out_last"}, 32'(bus.out_last), 32'd0);
    check({tag, " rd_addr"}, 32'(bus.rd_addr), 32'd0);
    check({tag, " out_addr"}, 32'(bus.out_addr), 32'd0);
    check({tag, " out_data"}, bus.out_data, 32'd0);
  endtask

  task automatic pushDump();
    beat_t b;
    for (int i = 0; i < NUM_REGS; i++) begin
      b.addr = ADDR_W'(i);
      b.data = regs[i];
`ifdef REGFILE_DUMP_CHECKSUM_EN
      b.last = 1'b0;
`else
      b.last = (i == NUM_REGS - 1);
`endif
      expQ.push_back(b);
    end
  endtask

`ifdef REGFILE_DUMP_CHECKSUM_EN
  task automatic pushCsum(input logic [DATA_W-1:0] csum);
    beat_t b;
    b.addr = '0;
    b.data = csum;
    b.last = 1'b1;
    expQ.push_back(b);
  endtask
`endif

  // Start cycle is numbered 1; after return the bench sits #1 into cycle 2
  task automatic pulseStart();
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic applyStimulus(input int stallAddr, input int stallCycles, input int pokeAddr,
                               output int doneAt);
    int  n = 2;
    int  stalls = 0;
    int  firstValid = -1;
    bit  poked = 1'b0;
    doneAt = -1;
    while (n < 400) begin
      bus.start = 1'b0;
      if (bus.out_valid && int'(bus.out_addr) == stallAddr && !bus.out_last && stalls < stallCycles) begin
        bus.out_ready = 1'b0;
        stalls++;
      end else begin
        bus.out_ready = 1'b1;
      end
      if (bus.out_valid && int'(bus.out_addr) == pokeAddr && !poked) begin
        regs[pokeAddr] = 32'hDEAD_BEEF;
        bus.start = 1'b1;
        poked = 1'b1;
      end
      @(negedge clk);
      if (firstValid < 0 && bus.out_valid) firstValid = n;
      check("busy during dump", 32'(bus.busy), 32'd1);
      if (bus.done) begin
        doneAt = n;
        break;
      end
      @(posedge clk);
      #1 n++;
    end
    bus.start = 1'b0;
    check("first beat cycle", 32'(firstValid), 32'd3);
    @(posedge clk);
    #1;
    check("busy after done", 32'(bus.busy), 32'd0);
    check("done after done", 32'(bus.done), 32'd0);
    check("pending beats", 32'(expQ.size()), 32'd0);
  endtask

  // Every presented beat is compared against the queue head; it is popped only on handshake
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL extra beat: got addr=%0d data=0x%08h, required no beat", bus.out_addr, bus.out_data);
      end else begin
        monExp = expQ[0];
        check("beat addr", 32'(bus.out_addr), 32'(monExp.addr));
        check("beat data", bus.out_data, monExp.data);
        check("beat last", 32'(bus.out_last), 32'(monExp.last));
        if (bus.out_ready) void'(expQ.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    total++;
    bad++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) regs[i] = '0;

    repeat (5) begin
      @(posedge clk);
      #1 bus.start = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      #1 checkIdleOutputs("reset");
    end
    bus.start = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1 bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("idle out_valid", 32'(bus.out_valid), 32'd0);
      check("idle busy", 32'(bus.busy), 32'd0);
    end

    $display("[TB] full dump, no backpressure");
    for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'h1000_0000 + i;
    pushDump();
`ifdef REGFILE_DUMP_CHECKSUM_EN
    pushCsum(32'h0000_0000);
`endif
    pulseStart();
    applyStimulus(-1, 0, -1, doneCycle);
    check("done cycle full", 32'(doneCycle), 32'(2 + 2 * NUM_REGS + CSUM_EXTRA));

    $display("[TB] backpressure on beat 3, write and start during beat 7");
    pushDump();
`ifdef REGFILE_DUMP_CHECKSUM_EN
    pushCsum(32'h0000_0000);
`endif
    pulseStart();
    applyStimulus(3, 5, 7, doneCycle);
    check("done cycle stalled", 32'(doneCycle), 32'(2 + 2 * NUM_REGS + CSUM_EXTRA + 5));
    regs[7] = 32'h1000_0007;

    $display("[TB] reset during beat 10");
    pushDump();
    pulseStart();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (bus.out_valid && bus.out_addr == 5'd10) break;
      @(posedge clk);
      #1;
    end
    check("reached beat 10", 32'(bus.out_addr), 32'd10);
    rst_n = 1'b0;
    #1 checkIdleOutputs("mid-dump reset");
    expQ.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pushDump();
`ifdef REGFILE_DUMP_CHECKSUM_EN
    pushCsum(32'h0000_0000);
`endif
    pulseStart();
    applyStimulus(-1, 0, -1, doneCycle);
    check("done cycle after reset", 32'(doneCycle), 32'(2 + 2 * NUM_REGS + CSUM_EXTRA));

`ifdef REGFILE_DUMP_CHECKSUM_EN
    $display("[TB] checksum beat");
    for (int i = 0; i < NUM_REGS; i++) regs[i] = '0;
    regs[5] = 32'h0000_00F0;
    regs[9] = 32'h0000_000F;
    pushDump();
    pushCsum(32'h0000_00FF);
    pulseStart();
    applyStimulus(-1, 0, -1, doneCycle);
    check("done cycle checksum", 32'(doneCycle), 32'(2 + 2 * NUM_REGS + 1));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug read-out engine that sits on the read side of the CPU register file.
- On a start pulse, it drives one register-file read address at a time and captures the returned data.
- Each captured word is streamed out as an (address, data) beat on a valid/ready interface, which feeds the debug UART/trace path.
- It owns one read port of the register file. The read port is combinational: data for rd_addr is valid in the same cycle.

Parameters:
- ADDR_W, 5, register index width.
- DATA_W, 32, register data width.
- NUM_REGS, 32, number of registers dumped, indices 0..NUM_REGS-1. Legal range is 1..2^ADDR_W.

Ports:
- clk  in  1  system clock. All state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a dump. Honoured only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle pulse when the final beat is accepted.
- rd_addr  out  ADDR_W  register-file read address.
- rd_data  in  DATA_W  register-file read data, combinational from rd_addr.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_addr  out  ADDR_W  register index of the current beat.
- out_data  out  DATA_W  captured register value.
- out_last  out  1  marks the final beat of a dump.

Behaviour:
- Reset (async assert, sync-free release): state=IDLE, idx=0. All outputs 0: busy, done, out_valid, out_last, rd_addr, out_addr, out_data.
- State machine: IDLE, READ, SEND, DONE.
  - IDLE: rd_addr=0. start=1 → idx←0, go to READ. Otherwise stay.
  - READ (exactly one cycle): rd_addr=idx. On the clock edge, out_data←rd_data, out_addr←idx, out_valid←1, out_last←(idx==NUM_REGS-1). Go to SEND.
  - SEND: rd_addr holds idx. out_valid, out_addr, out_data and out_last stay stable until a handshake (out_valid&&out_ready at a clock edge).
    - On handshake with idx<NUM_REGS-1: out_valid←0, idx←idx+1, go to READ.
    - On handshake with idx==NUM_REGS-1: out_valid←0, out_last←0, go to DONE.
  - DONE (one cycle): done=1, busy=0 on exit. Go to IDLE.
- Latency: the first beat is valid 2 cycles after the cycle in which start is sampled. Throughput is 1 beat per 2 cycles with out_ready held high. A full dump of 32 registers with no backpressure takes 2+2*32 cycles from start to the done pulse.
- Data is snapshotted in READ. A register-file write to the same index during SEND does not alter out_data.
- start during READ, SEND or DONE is ignored. No queuing.
- out_ready while out_valid=0 has no effect.
- idx never wraps. The comparison against NUM_REGS-1 is done at ADDR_W bits.
- NUM_REGS=1: a single beat with out_last=1.
- rst_n asserted mid-dump: immediate return to IDLE with all outputs 0. The partial dump is abandoned and not resumed.

Optional Feature:
- Macro: REGFILE_DUMP_CHECKSUM_EN.
- Defined:
  - A DATA_W running XOR is cleared on start acceptance and accumulates each captured word in READ.
  - After the last register beat is handshaken, the FSM enters state CSUM and presents one extra beat: out_addr=0, out_data=XOR of all dumped words, out_last=1. The register beat for index NUM_REGS-1 then has out_last=0.
  - DONE follows the CSUM handshake.
  - A full dump then takes 2+2*32+1 cycles without backpressure.
- Not defined: no accumulator, no CSUM state. Behaviour is exactly as above.

Test Plan:
- Reset values: hold rst_n=0 with random inputs → all outputs 0. Release, then wait 10 idle cycles → out_valid stays 0 and busy stays 0.
- Full dump, no backpressure: preload register i with 0x1000_0000+i, pulse start, hold out_ready=1.
  - Expect 32 beats: addr 0..31, data 0x1000_0000..0x1000_001F.
  - out_last only on addr 31; done pulse at cycle 66 after start.
- Backpressure: out_ready=0 for 5 cycles on beat 3 → out_addr=3 and out_data=0x1000_0003 stay stable throughout, and no beat is skipped or duplicated.
- Snapshot and ignored start: during the SEND of beat 7, write 0xDEAD_BEEF to register 7 and pulse start → out_data stays 0x1000_0007, and the dump continues without restarting.
- Reset mid-dump: assert rst_n=0 during beat 10 → outputs 0 immediately. A new start then dumps again from addr 0.
- With REGFILE_DUMP_CHECKSUM_EN: registers all 0 except reg5=0x0000_00F0 and reg9=0x0000_000F → 33rd beat out_data=0x0000_00FF with out_last=1, and beat 31 has out_last=0.
